// File: rtl/serial_op_unit_if.sv
// Operand/opcode offer and result return between decode stage and operator unit.
// Both directions use a valid/ready handshake; a transfer happens when both are high.
// master = producer/consumer side, slave = serial_op_unit.
interface serial_op_unit_if #(
    parameter int WIDTH = 32
);
    // operand/opcode offer
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    // result return
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    modport master (
        output in_valid,
        output op,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  div_by_zero
    );

    modport slave (
        input  in_valid,
        input  op,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output div_by_zero
    );
endinterface

// File: rtl/serial_op_unit.sv
// Two-operand operator unit: single-cycle ALU ops, iterative shift-add MUL and restoring DIV/MOD.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/DIV/MOD (accept edge to out_valid).
// Backpressure: in_ready only in IDLE; result and div_by_zero held in DONE until out_ready.
module serial_op_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    serial_op_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_MOD  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_LES  = 4'd7;
    localparam logic [3:0] OP_GES  = 4'd8;
    localparam logic [3:0] OP_EQ   = 4'd9;
    localparam logic [3:0] OP_NE   = 4'd10;
    localparam logic [3:0] OP_RAND = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;
    localparam logic [3:0] OP_RXOR = 4'd13;

    // Shift amounts at or above this give zero.
    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);
    // Counter value during the final iteration cycle.
    localparam logic [CW-1:0]    CNT_LAST    = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             dbz_q;

    // Captured opcode and iteration working registers.
    // MUL: x = multiplicand (shifts left), y = multiplier (shifts right), acc = partial product.
    // DIV/MOD: x = dividend shifting out MSB-first and collecting quotient bits, y = divisor,
    //          rem = partial remainder.
    logic [3:0]       op_q;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] single_res;
    logic             is_iter;

    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quot_nxt;

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;

    assign is_iter = (bus.op == OP_MUL) || (bus.op == OP_DIV) || (bus.op == OP_MOD);

    // Single-cycle result straight from the offered operands; 1-bit results zero-extended.
    always_comb begin
        single_res = '0;
        case (bus.op)
            OP_ADD:  single_res = bus.a + bus.b;
            OP_SUB:  single_res = bus.a - bus.b;
            OP_SHL:  single_res = (bus.b >= SHIFT_LIMIT) ? '0 : (bus.a << bus.b);
            OP_SHR:  single_res = (bus.b >= SHIFT_LIMIT) ? '0 : (bus.a >> bus.b);
            OP_LES:  single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) <= $signed(bus.b))};
            OP_GES:  single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) >= $signed(bus.b))};
            OP_EQ:   single_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            OP_NE:   single_res = {{(WIDTH-1){1'b0}}, (bus.a != bus.b)};
            OP_RAND: single_res = {{(WIDTH-1){1'b0}}, (&bus.a)};
            OP_ROR:  single_res = {{(WIDTH-1){1'b0}}, (|bus.a)};
            OP_RXOR: single_res = {{(WIDTH-1){1'b0}}, (^bus.a)};
            default: single_res = '0;
        endcase
    end

    // One iteration step for both iterative datapaths.
    // With a zero divisor every step subtracts nothing, so the quotient fills with ones
    // and the remainder ends up equal to the dividend, which is exactly the required output.
    always_comb begin
        acc_nxt  = acc + (y[0] ? x : '0);
        rem_sh   = {rem, x[WIDTH-1]};
        rem_sub  = rem_sh - {1'b0, y};
        q_bit    = (rem_sh >= {1'b0, y});
        rem_nxt  = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quot_nxt = {x[WIDTH-2:0], q_bit};
    end

    // Control FSM with registered handshake outputs, result and working registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            dbz_q       <= 1'b0;
            op_q        <= '0;
            x           <= '0;
            y           <= '0;
            acc         <= '0;
            rem         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q       <= bus.op;
                        in_ready_q <= 1'b0;
                        if (is_iter) begin
                            state <= BUSY;
                            x     <= bus.a;
                            y     <= bus.b;
                            acc   <= '0;
                            rem   <= '0;
                            cnt   <= '0;
                            dbz_q <= (bus.op != OP_MUL) && (bus.b == '0);
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= single_res;
                            dbz_q       <= 1'b0;
                        end
                    end
                end

                BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (op_q == OP_MUL) begin
                        acc <= acc_nxt;
                        x   <= x << 1;
                        y   <= y >> 1;
                    end else begin
                        rem <= rem_nxt;
                        x   <= quot_nxt;
                    end
                    // Final iteration: publish the freshly computed value.
                    if (cnt == CNT_LAST) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        if (op_q == OP_MUL) begin
                            result_q <= acc_nxt;
                        end else if (op_q == OP_DIV) begin
                            result_q <= quot_nxt;
                        end else begin
                            result_q <= rem_nxt;
                        end
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_op_unit.sv
// Bench for serial_op_unit: directed vector table, hold/reset sequences, random ops vs model.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// Summary line reports total comparisons and failures.
module tb_serial_op_unit;

    localparam int W = 32;

    logic clk;
    logic rst;

    serial_op_unit_if #(.WIDTH(W)) bus ();

    serial_op_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         dbz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the operator table, using plain arithmetic.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic z, output int lat);
        r = '0;
        z = 1'b0;
        lat = 1;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  begin r = a * b; lat = W + 1; end
            4'd3:  begin
                       lat = W + 1;
                       if (b == 0) begin r = '1; z = 1'b1; end
                       else r = a / b;
                   end
            4'd4:  begin
                       lat = W + 1;
                       if (b == 0) begin r = a; z = 1'b1; end
                       else r = a % b;
                   end
            4'd5:  r = (b >= W) ? '0 : a << b;
            4'd6:  r = (b >= W) ? '0 : a >> b;
            4'd7:  r = W'($signed(a) <= $signed(b));
            4'd8:  r = W'($signed(a) >= $signed(b));
            4'd9:  r = W'(a == b);
            4'd10: r = W'(a != b);
            4'd11: r = W'(&a);
            4'd12: r = W'(|a);
            4'd13: r = W'(^a);
            default: r = '0;
        endcase
    endfunction

    // Offer one op, scramble inputs after accept, measure latency, hold `hold` cycles, consume.
    task automatic do_op(input logic [3:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         input int hold, output logic [W-1:0] res_o, output logic dbz_o, output int lat_o);
        int k;
        bus.in_valid = 1'b1;
        bus.op = op_i;
        bus.a = a_i;
        bus.b = b_i;
        k = 0;
        while (!bus.in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("accept_wait", 64'(k), 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
        check("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
        lat_o = 1;
        while (!bus.out_valid && lat_o < 200) begin
            @(posedge clk); #1;
            lat_o++;
        end
        res_o = bus.result;
        dbz_o = bus.div_by_zero;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            bus.a = $urandom;
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_result", 64'(bus.result), 64'(res_o));
            check("hold_dbz", 64'(bus.div_by_zero), 64'(dbz_o));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("consume_out_valid", 64'(bus.out_valid), 64'd0);
        check("consume_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    vec_t vecs[$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r, er;
        logic         z, ez;
        int           lat, elat, seen;

        vecs.push_back('{4'd0,  32'd5,          32'd10,         32'd15,         1'b0});
        vecs.push_back('{4'd1,  32'd5,          32'd10,         32'hFFFFFFFB,   1'b0});
        vecs.push_back('{4'd3,  32'd10,         32'd5,          32'd2,          1'b0});
        vecs.push_back('{4'd4,  32'd10,         32'd3,          32'd1,          1'b0});
        vecs.push_back('{4'd2,  32'd10,         32'd5,          32'd50,         1'b0});
        vecs.push_back('{4'd3,  32'd7,          32'd0,          32'hFFFFFFFF,   1'b1});
        vecs.push_back('{4'd4,  32'd7,          32'd0,          32'd7,          1'b1});
        vecs.push_back('{4'd7,  32'hFFFFFFF6,   32'd10,         32'd1,          1'b0});
        vecs.push_back('{4'd8,  32'hFFFFFFF6,   32'd10,         32'd0,          1'b0});
        vecs.push_back('{4'd11, 32'hFFFFFFFF,   32'd0,          32'd1,          1'b0});
        vecs.push_back('{4'd13, 32'd9,          32'd0,          32'd0,          1'b0});
        vecs.push_back('{4'd5,  32'd9,          32'd40,         32'd0,          1'b0});
        vecs.push_back('{4'd5,  32'd1,          32'd31,         32'h80000000,   1'b0});
        vecs.push_back('{4'd6,  32'h80000000,   32'd31,         32'd1,          1'b0});
        vecs.push_back('{4'd6,  32'hDEADBEEF,   32'd32,         32'd0,          1'b0});
        vecs.push_back('{4'd9,  32'd3,          32'd3,          32'd1,          1'b0});
        vecs.push_back('{4'd10, 32'd3,          32'd3,          32'd0,          1'b0});
        vecs.push_back('{4'd12, 32'd0,          32'd0,          32'd0,          1'b0});
        vecs.push_back('{4'd14, 32'd123,        32'd45,         32'd0,          1'b0});
        vecs.push_back('{4'd15, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0});
        vecs.push_back('{4'd2,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0});
        vecs.push_back('{4'd3,  32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0});
        vecs.push_back('{4'd4,  32'd5,          32'd9,          32'd5,          1'b0});
        vecs.push_back('{4'd8,  32'h80000000,   32'h7FFFFFFF,   32'd0,          1'b0});

        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_result", 64'(bus.result), 64'd0);
        check("reset_dbz", 64'(bus.div_by_zero), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table.
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r, z, lat);
            elat = (vecs[i].op inside {4'd2, 4'd3, 4'd4}) ? W + 1 : 1;
            check($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].res));
            check($sformatf("vec%0d_dbz", i), 64'(z), 64'(vecs[i].dbz));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(elat));
        end

        // Result held under backpressure, then back-to-back ops.
        do_op(4'd0, 32'd100, 32'd23, 5, r, z, lat);
        check("hold_add_result", 64'(r), 64'd123);
        do_op(4'd3, 32'd100, 32'd0, 5, r, z, lat);
        check("hold_div0_result", 64'(r), 64'hFFFFFFFF);
        check("hold_div0_dbz", 64'(z), 64'd1);
        do_op(4'd1, 32'd1, 32'd1, 0, r, z, lat);
        check("after_hold_sub", 64'(r), 64'd0);
        check("after_hold_dbz", 64'(z), 64'd0);

        // Reset in the middle of a multiply.
        bus.in_valid = 1'b1;
        bus.op = 4'd2;
        bus.a = 32'd1234;
        bus.b = 32'd5678;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("mid_mul_busy", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_result", 64'(bus.result), 64'd0);
        check("mid_rst_dbz", 64'(bus.div_by_zero), 64'd0);
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        bus.out_ready = 1'b0;
        check("no_stale_result", 64'(seen), 64'd0);
        do_op(4'd2, 32'd7, 32'd6, 0, r, z, lat);
        check("post_rst_mul", 64'(r), 64'd42);
        check("post_rst_mul_latency", 64'(lat), 64'(W + 1));

        // Random ops against the model.
        for (int n = 0; n < 300; n++) begin
            logic [3:0]   op_r;
            logic [W-1:0] a_r, b_r;
            op_r = 4'($urandom_range(0, 15));
            a_r = $urandom;
            case ($urandom_range(0, 3))
                0: b_r = W'($urandom_range(0, 40));
                1: b_r = '0;
                2: b_r = a_r;
                default: b_r = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) a_r = W'($urandom_range(0, 20));
            model(op_r, a_r, b_r, er, ez, elat);
            do_op(op_r, a_r, b_r, $urandom_range(0, 2), r, z, lat);
            check($sformatf("rand%0d_op%0d_result", n, op_r), 64'(r), 64'(er));
            check($sformatf("rand%0d_op%0d_dbz", n, op_r), 64'(z), 64'(ez));
            check($sformatf("rand%0d_op%0d_latency", n, op_r), 64'(lat), 64'(elat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
